de10_bus_arbiter: RTL

//  Shares the single DE10 memory bus (SRAM / peripherals / SDRAM, region by addr[31:22]) between fetch (m0, read-only) and data (m1, r/w).

---
 rtl/de10_bus_arbiter_pkg.sv | 26 ++
 rtl/de10_rr_arbiter2.sv | 29 ++
 rtl/de10_bus_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/de10_bus_arbiter_pkg.sv
// rtl/de10_bus_arbiter_pkg.sv - region tags, FSM states and master ids for the DE10 bus arbiter
package de10_bus_arbiter_pkg;

    localparam logic [9:0] TAG_SRAM   = 10'h0;
    localparam logic [9:0] TAG_PERIPH = 10'h1;
    localparam logic [9:0] TAG_SDRAM  = 10'h2;
    localparam int         TAG_MSB    = 31;
    localparam int         TAG_LSB    = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    // Tags above SDRAM have no target behind the decoder.
    function automatic logic tag_mapped(input logic [9:0] tag);
        return (tag == TAG_SRAM) || (tag == TAG_PERIPH) || (tag == TAG_SDRAM);
    endfunction

endpackage

// File: rtl/de10_rr_arbiter2.sv
// rtl/de10_rr_arbiter2.sv - two-way round-robin picker; remembers the last winner
module de10_rr_arbiter2
    import de10_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    master_t last_grant;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == M0) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= M0;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1] ? M1 : M0;
        end
    end

endmodule

// File: rtl/de10_bus_arbiter.sv
// rtl/de10_bus_arbiter.sv - shares the DE10 memory bus between fetch (m0) and data (m1)
// Optional BUS_TIMEOUT_EN aborts a BUSY transaction after TIMEOUT_CYCLES cycles.
module de10_bus_arbiter
    import de10_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_we,
    input  logic [DATA_W/8-1:0] m1_be,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    output logic                bus_valid,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ready
);

    state_t            state;
    master_t           owner;
    logic [1:0]        grant;
    logic              advance;
    logic              sel_m1;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_mapped;
    logic              done;
    logic              done_err;
    logic              done_m1;
    logic [DATA_W-1:0] done_data;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tcount;
    logic             timed_out;

    assign timed_out = (tcount == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcount <= '0;
        end else if (state == ST_IDLE) begin
            tcount <= '0;
        end else if ((state == ST_BUSY) && !bus_ready) begin
            tcount <= tcount + 1'b1;
        end
    end
`endif

    assign advance    = (state == ST_IDLE) && (m0_req || m1_req);
    assign sel_m1     = grant[1];
    assign sel_addr   = sel_m1 ? m1_addr : m0_addr;
    assign sel_mapped = tag_mapped(sel_addr[TAG_MSB:TAG_LSB]);
    assign done_m1    = (state == ST_IDLE) ? sel_m1 : (owner == M1);

    de10_rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({m1_req, m0_req}),
        .advance (advance),
        .grant   (grant)
    );

    // Completion source: local unmapped answer from IDLE, target ready or abort from BUSY.
    always_comb begin
        done      = 1'b0;
        done_err  = 1'b0;
        done_data = '0;
        case (state)
            ST_IDLE: begin
                if (advance && !sel_mapped) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus_ready) begin
                    done      = 1'b1;
                    done_data = bus_we ? '0 : bus_rdata;
                end
`ifdef BUS_TIMEOUT_EN
                else if (timed_out) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
`endif
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= M0;
            bus_valid <= 1'b0;
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_wdata <= '0;
            m0_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_ack    <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (advance) begin
                        owner <= sel_m1 ? M1 : M0;
                        if (sel_mapped) begin
                            state     <= ST_BUSY;
                            bus_valid <= 1'b1;
                            bus_addr  <= sel_addr;
                            bus_we    <= sel_m1 & m1_we;
                            bus_be    <= sel_m1 ? m1_be : '1;
                            bus_wdata <= sel_m1 ? m1_wdata : '0;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        state     <= ST_RESP;
                        bus_valid <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (done) begin
                if (done_m1) begin
                    m1_ack   <= 1'b1;
                    m1_err   <= done_err;
                    m1_rdata <= done_data;
                end else begin
                    m0_ack   <= 1'b1;
                    m0_err   <= done_err;
                    m0_rdata <= done_data;
                end
            end
        end
    end

endmodule
